// File: rtl/code_shift_display_if.sv
// Board-facing pins of the scrolling code display: slow step input, controls, and active-low drive.
// master = stimulus side, slave = display block.
interface code_shift_display_if #(
  parameter int NDIG = 8
);
  logic            clk_1hz;
  logic            run;
  logic            dir;
  logic            load;
  logic [6:0]      seg;
  logic [NDIG-1:0] an;
  logic            dp;

  modport master (
    output clk_1hz, run, dir, load,
    input  seg, an, dp
  );

  modport slave (
    input  clk_1hz, run, dir, load,
    output seg, an, dp
  );
endinterface

// File: rtl/code_shift_display.sv
// Rotates an NDIG-digit code on each clk_1hz rising edge and scans it onto a muxed 7-seg display; DP_MARK_EN adds a home-digit dp marker.
// Latency: step reaches the digit register 3 clk after clk_1hz is first sampled high; display pins are registered (+1 clk).
// No backpressure: steps while run=0 are dropped, not queued.
module code_shift_display #(
  parameter int          NDIG     = 8,
  parameter logic [31:0] CODE     = 32'h2021_3456,
  parameter int          SCAN_DIV = 50_000
) (
  input logic                 clk,
  input logic                 rst,
  code_shift_display_if.slave io
);

  localparam int              DW        = 4 * NDIG;
  localparam int              IDXW      = $clog2(NDIG);
  localparam int              CNTW      = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   CODE_INIT = CODE[DW-1:0];
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(SCAN_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hF:    s = 7'b1111111;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // clk_1hz is asynchronous: s1/s2 resynchronize, s3 holds the previous level for edge detection.
  logic s1, s2, s3;
  logic step;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= io.clk_1hz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3 & io.run;

  logic [DW-1:0] digits;
  logic [DW-1:0] rot_left;
  logic [DW-1:0] rot_right;

  assign rot_left  = {digits[DW-5:0], digits[DW-1:DW-4]};
  assign rot_right = {digits[3:0], digits[DW-1:4]};

  always_ff @(posedge clk) begin
    if (rst || io.load) begin
      digits <= CODE_INIT;
    end else if (step) begin
      digits <= io.dir ? rot_right : rot_left;
    end
  end

  logic [CNTW-1:0] scan_cnt;
  logic [IDXW-1:0] idx;
  logic            scan_wrap;

  assign scan_wrap = (scan_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0]      cur_digit;
  logic [6:0]      seg_nxt;
  logic [NDIG-1:0] an_nxt;
  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;

  assign cur_digit = digits[{idx, 2'b00} +: 4];
  assign seg_nxt   = seg_decode(cur_digit);

  always_comb begin
    an_nxt      = '1;
    an_nxt[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
    end
  end

  assign io.seg = seg_q;
  assign io.an  = an_q;

`ifdef DP_MARK_EN
  // home tracks which position original digit 0 has rotated into.
  logic [IDXW-1:0] home;
  logic            dp_q;

  always_ff @(posedge clk) begin
    if (rst || io.load) begin
      home <= '0;
    end else if (step) begin
      if (io.dir) begin
        home <= (home == '0) ? IDX_LAST : home - 1'b1;
      end else begin
        home <= (home == IDX_LAST) ? '0 : home + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= (idx != home);
    end
  end

  assign io.dp = dp_q;
`else
  assign io.dp = 1'b1;
`endif

endmodule

// File: tb/tb_code_shift_display.sv
// Bench for code_shift_display: table of step/load/reset scenarios checked by scanning the display through a scoreboard,
// plus hand sequences for reset release, step latency and mid-step reset.
module tb_code_shift_display;

  localparam int          NDIG     = 8;
  localparam int          SCAN_DIV = 4;
  localparam logic [31:0] CODE     = 32'h2021_3456;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_shift_display_if #(.NDIG(NDIG)) io ();

  code_shift_display #(
    .NDIG    (NDIG),
    .CODE    (CODE),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  // mode: 0 = plain clk_1hz pulses, 1 = load asserted in the step cycle, 2 = reset one cycle after clk_1hz rises
  typedef struct {
    bit          do_rst;
    bit          run;
    bit          dir;
    int          n_edges;
    int          hi_cyc;
    int          mode;
    logic [31:0] exp_code;
    int          exp_home;
  } vec_t;

  typedef struct {
    logic [55:0] segs;
    logic [7:0]  dps;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hF:    return 7'b1111111;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [7:0] exp_dp_mask(input int home);
`ifdef DP_MARK_EN
    return ~(8'b1 << home);
`else
    return 8'hFF;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_expected(input logic [31:0] code, input int home);
    exp_t e;
    for (int k = 0; k < NDIG; k++) e.segs[7*k +: 7] = dec7(code[4*k +: 4]);
    e.dps = exp_dp_mask(home);
    sb.push_back(e);
  endtask

  // One full refresh period: every slot must light for SCAN_DIV cycles with exactly one anode low.
  task automatic capture_and_check(input int vi);
    logic [55:0] segs;
    logic [7:0]  dps;
    int          cnt[8];
    bit          bad;
    bit          found;
    bit          cnt_ok;
    exp_t        e;
    segs = '0;
    dps  = '1;
    bad  = 1'b0;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int c = 0; c < NDIG * SCAN_DIV; c++) begin
      @(negedge clk);
      found = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        if (io.an == ~(8'b1 << k)) begin
          segs[7*k +: 7] = io.seg;
          dps[k]         = io.dp;
          cnt[k]++;
          found = 1'b1;
        end
      end
      if (!found) bad = 1'b1;
    end
    cnt_ok = 1'b1;
    for (int k = 0; k < NDIG; k++) if (cnt[k] != SCAN_DIV) cnt_ok = 1'b0;
    check($sformatf("v%0d an_onehot", vi), {63'd0, bad}, 64'd0);
    check($sformatf("v%0d slot_len", vi), {63'd0, cnt_ok}, 64'd1);
    if (sb.size() == 0) begin
      check($sformatf("v%0d sb_empty", vi), 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d segs", vi), {8'd0, segs}, {8'd0, e.segs});
      check($sformatf("v%0d dp", vi), {56'd0, dps}, {56'd0, e.dps});
    end
  endtask

  task automatic apply(input int vi, input vec_t v);
    if (v.do_rst) begin
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
    end
    io.run = v.run;
    io.dir = v.dir;
    push_expected(v.exp_code, v.exp_home);
    case (v.mode)
      1: begin
        io.clk_1hz = 1'b1;
        tick(2);
        io.load = 1'b1;
        tick(1);
        io.load = 1'b0;
        tick(v.hi_cyc);
        io.clk_1hz = 1'b0;
        tick(6);
      end
      2: begin
        io.clk_1hz = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        check($sformatf("v%0d rst_blank", vi), {48'd0, io.an, io.seg, io.dp}, {48'd0, 8'hFF, 7'h7F, 1'b1});
        rst        = 1'b0;
        io.clk_1hz = 1'b0;
        tick(6);
      end
      default: begin
        for (int p = 0; p < v.n_edges; p++) begin
          io.clk_1hz = 1'b1;
          tick(v.hi_cyc);
          io.clk_1hz = 1'b0;
          tick(6);
        end
      end
    endcase
    capture_and_check(vi);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 6,   0, 32'h2021_3456, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1, 6,   0, 32'h0213_4562, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1, 6,   0, 32'h2134_5620, 2};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1, 100, 0, 32'h6202_1345, 7};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3, 6,   0, 32'h2021_3456, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1, 6,   0, 32'h0213_4562, 1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1, 6,   1, 32'h2021_3456, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1, 6,   0, 32'h0213_4562, 1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1, 6,   2, 32'h2021_3456, 0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 2, 6,   0, 32'h5620_2134, 6};

    rst        = 1'b1;
    io.clk_1hz = 1'b0;
    io.run     = 1'b0;
    io.dir     = 1'b0;
    io.load    = 1'b0;
    tick(3);
    check("reset_state", {48'd0, io.an, io.seg, io.dp}, {48'd0, 8'hFF, 7'h7F, 1'b1});

    // Reset release: slot 0 shows "6" for SCAN_DIV cycles, then slot 1 shows "5".
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ean;
      logic [6:0] eseg;
      logic       edp;
      @(negedge clk);
      ean  = (i < 4) ? 8'hFE : 8'hFD;
      eseg = (i < 4) ? dec7(4'h6) : dec7(4'h5);
      edp  = exp_dp_mask(0)[(i < 4) ? 0 : 1];
      check($sformatf("release_c%0d", i), {48'd0, io.an, io.seg, io.dp}, {48'd0, ean, eseg, edp});
    end

    // Step latency: align to the first slot-0 cycle after reset, then raise clk_1hz.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    io.run     = 1'b1;
    io.dir     = 1'b0;
    io.clk_1hz = 1'b1;
    tick(3);
    check("lat_edge3", {56'd0, io.an, io.seg[6:0], 1'b0}, {56'd0, 8'hFE, dec7(4'h6), 1'b0});
    tick(1);
    check("lat_edge4", {56'd0, io.an, io.seg[6:0], 1'b0}, {56'd0, 8'hFD, dec7(4'h6), 1'b0});
    io.clk_1hz = 1'b0;
    io.run     = 1'b0;
    tick(6);

    for (int vi = 0; vi < 10; vi++) apply(vi, vecs[vi]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_shift_display.md
# code_shift_display

Steps an 8-digit student code across a multiplexed 7-segment display, rotating by one digit per rising edge of the 1 Hz divider output. It sits directly downstream of the clock divider: it treats `clk_1hz` as a slow data input, synchronizes it and edge-detects it into a one-cycle step enable. It then drives the board's active-low segment and anode pins. Everything runs on the single board clock.

## Interface
- `NDIG`, 8: number of display digits. Supported range is 2..8.
- `CODE`, 32'h2021_3456: reset/load contents, 4 bits per digit. Digit i = `CODE[4i+3:4i]`; digit 0 is rightmost.
- `SCAN_DIV`, 50_000: clk cycles per digit scan slot. Minimum value is 2.

Ports:
- `clk`  in  1  board clock (50 MHz).
- `rst`  in  1  reset, synchronous, active-high.
- `clk_1hz`  in  1  slow square wave from the divider. Asynchronous to the logic; sampled only.
- `run`  in  1  1 = step on each `clk_1hz` rising edge; 0 = hold.
- `dir`  in  1  0 = rotate left, 1 = rotate right.
- `load`  in  1  synchronous reload of `CODE` into the digit register.
- `seg`  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- `an`  out  NDIG  active-low digit enables; `an[0]` is the rightmost digit.
- `dp`  out  1  active-low decimal point.

## Operation
- Synchronizer and edge detect:
  - 3-flop chain s1→s2→s3 on `clk_1hz`.
  - `step = s2 & ~s3 & run`.
- Digit register: 4*NDIG bits. Update priority is rst > load > step.
  - Rotate left (dir=0): `digit[i] ← digit[i-1]`, `digit[0] ← digit[NDIG-1]`. This is a rotate-left by 4 bits.
  - Rotate right (dir=1): the mirror operation, a rotate-right by 4 bits.
  - No step: hold.
- `load` and `step` in the same cycle: load wins and the step is discarded.
- `dir` is sampled in the step cycle only.
- Scan counter: counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap cycle, `idx` advances idx→idx+1, with NDIG-1 wrapping to 0.
- Output register, updated every cycle from the current `idx` and digit register:
  - `an` = all ones except bit `idx`, which is 0.
  - `seg` = decode of `digit[idx]`.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 0xA–0xE = 0111111 (dash).
  - 0xF = 1111111 (blank).
- A step and a scan wrap in the same cycle both take effect. Outputs reflect the new digits and new `idx` one cycle later.

## Timing
- Reset values:
  - Digits = `CODE`; s1=s2=s3=0; scan counter=0; `idx`=0.
  - `seg`=7'h7F, `an`=all ones, `dp`=1.
- The first enabled digit appears on the first edge after `rst` deasserts: `an`=...1110, showing digit 0.
- Step latency: number the first clk edge that samples `clk_1hz`=1 as edge 1. The `step` pulse is high during the cycle after edge 2. The digit register updates at edge 3.
- Exactly one step per `clk_1hz` rising edge. A falling edge produces no step.
- A `clk_1hz` high pulse shorter than 1 clk period is not guaranteed to be seen.
- `run` low at the step cycle: that edge is lost. It is not queued.
- `load`: the digit register equals `CODE` at the next edge. Display outputs follow one edge later.
- Each digit is enabled for exactly SCAN_DIV cycles. The full refresh period is NDIG*SCAN_DIV cycles.
- `rst` mid-operation:
  - Digits reload, scan restarts at idx 0, outputs go blank at that edge.
  - An in-flight synchronizer edge is cleared and no step is produced.

## Configuration
- `DP_MARK_EN`:
  - Defined: a 3-bit (log2 NDIG) home pointer tracks where original digit 0 currently sits. It resets/loads to 0, increments on a left step, decrements on a right step, and wraps mod NDIG. `dp`=0 whenever `idx` == home pointer, otherwise 1.
  - Undefined: no pointer logic; `dp` is tied to constant 1.

## Test plan
- Reset release, CODE=32'h2021_3456, SCAN_DIV=4: first edge after reset gives `an`=8'hFE, `seg`=0000010 ("6"). Then `an` steps FE→FD→FB… every 4 cycles; the idx1 slot shows `seg`=0010010 ("5").
- `run`=1, `dir`=0, one `clk_1hz` rising edge: digit register becomes 32'h0213_4562 at edge 3. A second rising edge gives 32'h2134_5620.
- `dir`=1 from reset, one step: register becomes 32'h6202_1345. Holding `clk_1hz` high for 100 cycles produces no further step.
- `run`=0 across 3 `clk_1hz` edges: register stays 32'h2021_3456. Then `load` and a step asserted in the same cycle: register equals CODE and no rotation occurs.
- `rst` asserted 1 cycle after `clk_1hz` rises, with `run`=1: no step occurs, outputs go blank, and digits equal CODE.
- With `DP_MARK_EN` defined:
  - After reset, `dp`=0 only in the idx0 slot.
  - After one left step, `dp`=0 only in the idx1 slot.
  - Without the macro, `dp`=1 in every slot.
